// File: rtl/pif_ram_arbiter.sv
// pif_ram_arbiter
//   Shares the single-port PIF RAM between the N64 serial engine and the host
//   CPU. N64 has fixed priority and may lock the RAM for a burst of up to
//   BURST_MAX beats. A starvation counter and a post-burst slot make sure the
//   CPU always gets through.
// Ports
//   clk, reset_l            clock, async active-low reset
//   n64_req/we/burst/addr/wdata -> n64_gnt, n64_rvalid, n64_rdata
//   cpu_req/we/be/addr/wdata    -> cpu_gnt, cpu_rvalid, cpu_rdata
//   ram_addr/we/be/wdata, ram_rdata   RAM macro side (registered read data)
//   n64_locked              status: arbiter is inside an N64 burst lock
module pif_ram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int BURST_MAX  = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              n64_req,
    input  logic              n64_we,
    input  logic              n64_burst,
    input  logic [ADDR_W-1:0] n64_addr,
    input  logic [DATA_W-1:0] n64_wdata,
    output logic              n64_gnt,
    output logic              n64_rvalid,
    output logic [DATA_W-1:0] n64_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              n64_locked
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, N64_LOCK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_N64, OWN_CPU} owner_t;

    state_t            state;
    owner_t            rd_owner;
    logic [BW-1:0]     beat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              cpu_slot;     // one-cycle CPU priority right after a burst
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] n64_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // Grants are gated by reset_l so every output reads 0 while reset is held.
    always_comb begin
        n64_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (reset_l) begin
            if (state == N64_LOCK)
                n64_gnt = n64_req & n64_burst;
            else if (cpu_req && (cpu_slot || starve_cnt == SW'(STARVE_MAX)))
                cpu_gnt = 1'b1;
            else if (n64_req)
                n64_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
        end
    end

    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 1'b0;
        ram_be    = 4'h0;
        ram_wdata = '0;
        if (n64_gnt) begin
            ram_addr  = n64_addr;
            ram_we    = n64_we;
            ram_be    = n64_we ? 4'hF : 4'h0;
            ram_wdata = n64_wdata;
        end else if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            // An all-zero byte mask still takes the slot but writes nothing.
            ram_we    = cpu_we & (|cpu_be);
            ram_be    = cpu_we ? cpu_be : 4'h0;
            ram_wdata = cpu_wdata;
        end
    end

    // Read data is live from the RAM in the return cycle, held afterwards.
    assign n64_rvalid = (rd_owner == OWN_N64);
    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign n64_rdata  = n64_rvalid ? ram_rdata : n64_rdata_q;
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign n64_locked = (state == N64_LOCK);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= IDLE;
            rd_owner    <= OWN_NONE;
            beat_cnt    <= '0;
            starve_cnt  <= '0;
            cpu_slot    <= 1'b0;
            ram_addr_q  <= '0;
            n64_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            ram_addr_q <= ram_addr;
            cpu_slot   <= 1'b0;

            if (cpu_req && !cpu_gnt) begin
                if (starve_cnt != SW'(STARVE_MAX))
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (n64_gnt && !n64_we)      rd_owner <= OWN_N64;
            else if (cpu_gnt && !cpu_we) rd_owner <= OWN_CPU;
            else                         rd_owner <= OWN_NONE;

            if (n64_rvalid) n64_rdata_q <= ram_rdata;
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;

            case (state)
                IDLE: begin
                    if (n64_gnt && n64_burst) begin
                        state    <= N64_LOCK;
                        beat_cnt <= BW'(1);
                    end
                end
                N64_LOCK: begin
                    if (!n64_burst) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        cpu_slot <= 1'b1;
                    end else if (n64_gnt) begin
                        if (beat_cnt == BW'(BURST_MAX - 1)) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            cpu_slot <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Directed bench for pif_ram_arbiter with a behavioural 512x32 RAM model.
module tb_pif_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_l;
    logic        n64_req, n64_we, n64_burst;
    logic [8:0]  n64_addr;
    logic [31:0] n64_wdata;
    logic        n64_gnt, n64_rvalid;
    logic [31:0] n64_rdata;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        n64_locked;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [512];

    always #5 clk = ~clk;

    pif_ram_arbiter dut (
        .clk(clk), .reset_l(reset_l),
        .n64_req(n64_req), .n64_we(n64_we), .n64_burst(n64_burst),
        .n64_addr(n64_addr), .n64_wdata(n64_wdata),
        .n64_gnt(n64_gnt), .n64_rvalid(n64_rvalid), .n64_rdata(n64_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .n64_locked(n64_locked)
    );

    // Registered-read RAM with byte enables.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        n64_req = 0; n64_we = 0; n64_burst = 0; n64_addr = '0; n64_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_l = 1'b0;
        #3;
        total_cnt++;
        if ({n64_gnt, cpu_gnt, n64_rvalid, cpu_rvalid, ram_we, n64_locked} !== 6'b0 ||
            ram_addr !== 9'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0 ||
            n64_rdata !== 32'h0 || cpu_rdata !== 32'h0)
            $display("FAIL reset_outputs: got gnt=%b/%b rv=%b/%b we=%b lk=%b addr=%h", n64_gnt,
                     cpu_gnt, n64_rvalid, cpu_rvalid, ram_we, n64_locked, ram_addr);
        else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        reset_l = 1'b1;
        step();
    endtask

    task automatic test_n64_read();
        n64_req = 1; n64_we = 0; n64_addr = 9'h010;
        @(negedge clk);
        total_cnt++;
        if (n64_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_addr !== 9'h010 || ram_we !== 1'b0)
            $display("FAIL n64_read_gnt: gnt=%b cgnt=%b addr=%h we=%b want 1 0 010 0",
                     n64_gnt, cpu_gnt, ram_addr, ram_we);
        else pass_cnt++;
        step();
        n64_req = 0;
        @(negedge clk);
        total_cnt++;
        if (n64_rvalid !== 1'b1 || n64_rdata !== 32'hC0DE0010 || cpu_rvalid !== 1'b0)
            $display("FAIL n64_read_data: rv=%b data=%h crv=%b want 1 c0de0010 0",
                     n64_rvalid, n64_rdata, cpu_rvalid);
        else pass_cnt++;
        step();
        @(negedge clk);
        total_cnt++;
        if (n64_rvalid !== 1'b0 || n64_rdata !== 32'hC0DE0010 || ram_addr !== 9'h010)
            $display("FAIL n64_read_hold: rv=%b data=%h addr=%h want 0 c0de0010 010",
                     n64_rvalid, n64_rdata, ram_addr);
        else pass_cnt++;
        step();
    endtask

    task automatic test_starve();
        n64_req = 1; n64_we = 0; n64_addr = 9'h030;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h031;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            total_cnt++;
            // cycle 10: starve counter was cleared by the CPU grant, N64 wins again
            if (n64_gnt !== (c != 9) || cpu_gnt !== (c == 9))
                $display("FAIL starve_cycle%0d: n64_gnt=%b cpu_gnt=%b want %b %b",
                         c, n64_gnt, cpu_gnt, c != 9, c == 9);
            else pass_cnt++;
            if (c == 10) begin
                total_cnt++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hC0DE0031 || n64_rvalid !== 1'b0)
                    $display("FAIL starve_cpu_rdata: rv=%b data=%h nrv=%b want 1 c0de0031 0",
                             cpu_rvalid, cpu_rdata, n64_rvalid);
                else pass_cnt++;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_burst();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h040;
        n64_req = 1; n64_we = 1; n64_burst = 1;
        for (int i = 0; i < 16; i++) begin
            n64_addr = 9'h100 + 9'(i); n64_wdata = 32'hB0000000 | i;
            @(negedge clk);
            total_cnt++;
            if (n64_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_we !== 1'b1 || ram_be !== 4'hF ||
                n64_locked !== (i != 0))
                $display("FAIL burst_beat%0d: gnt=%b cgnt=%b we=%b be=%h lk=%b", i, n64_gnt,
                         cpu_gnt, ram_we, ram_be, n64_locked);
            else pass_cnt++;
            step();
        end
        n64_addr = 9'h110;
        @(negedge clk);
        total_cnt++;
        if (cpu_gnt !== 1'b1 || n64_gnt !== 1'b0 || n64_locked !== 1'b0)
            $display("FAIL burst_cpu_slot: cgnt=%b gnt=%b lk=%b want 1 0 0",
                     cpu_gnt, n64_gnt, n64_locked);
        else pass_cnt++;
        step();
        idle_inputs();
        step();
        // short burst ended by n64_burst=0; CPU gets the slot before starve saturates
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h040;
        n64_req = 1; n64_we = 1; n64_burst = 1;
        n64_addr = 9'h120; n64_wdata = 32'h12; step();
        n64_addr = 9'h121; n64_wdata = 32'h13; step();
        n64_burst = 0; n64_addr = 9'h122;
        @(negedge clk);
        total_cnt++;
        if (n64_gnt !== 1'b0 || cpu_gnt !== 1'b0 || n64_locked !== 1'b1)
            $display("FAIL burst_exit: gnt=%b cgnt=%b lk=%b want 0 0 1", n64_gnt, cpu_gnt, n64_locked);
        else pass_cnt++;
        step();
        @(negedge clk);
        total_cnt++;
        if (cpu_gnt !== 1'b1 || n64_gnt !== 1'b0 || n64_locked !== 1'b0)
            $display("FAIL short_burst_slot: cgnt=%b gnt=%b lk=%b want 1 0 0",
                     cpu_gnt, n64_gnt, n64_locked);
        else pass_cnt++;
        step();
        cpu_req = 0;
        @(negedge clk);
        total_cnt++;
        if (n64_gnt !== 1'b1 || n64_locked !== 1'b0)
            $display("FAIL after_slot_n64: gnt=%b lk=%b want 1 0", n64_gnt, n64_locked);
        else pass_cnt++;
        step();
        idle_inputs();
        cpu_req = 1; cpu_addr = 9'h10F;
        step();
        cpu_req = 0;
        @(negedge clk);
        total_cnt++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB000000F)
            $display("FAIL burst_readback: rv=%b data=%h want 1 b000000f", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_byte_enable();
        n64_req = 1; n64_we = 1; n64_addr = 9'h020; n64_wdata = 32'h11223344;
        step();
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_be = 4'b0011; cpu_addr = 9'h020; cpu_wdata = 32'hAABBCCDD;
        @(negedge clk);
        total_cnt++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'b0011 || ram_wdata !== 32'hAABBCCDD)
            $display("FAIL cpu_be_write: gnt=%b we=%b be=%b wd=%h", cpu_gnt, ram_we, ram_be, ram_wdata);
        else pass_cnt++;
        step();
        cpu_be = 4'b0000; cpu_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        total_cnt++;
        if (cpu_gnt !== 1'b1 || ram_we !== 1'b0)
            $display("FAIL cpu_be_zero: gnt=%b we=%b want 1 0", cpu_gnt, ram_we);
        else pass_cnt++;
        step();
        cpu_we = 0;
        step();
        cpu_req = 0;
        @(negedge clk);
        total_cnt++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1122CCDD)
            $display("FAIL cpu_be_readback: rv=%b data=%h want 1 1122ccdd", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        n64_req = 1; n64_we = 0; n64_addr = 9'h010;
        step();
        n64_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h031;
        @(negedge clk);
        total_cnt++;
        if (n64_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || n64_rdata !== 32'hC0DE0010 || cpu_gnt !== 1'b1)
            $display("FAIL b2b_first: nrv=%b crv=%b nd=%h cgnt=%b", n64_rvalid, cpu_rvalid, n64_rdata, cpu_gnt);
        else pass_cnt++;
        step();
        cpu_req = 0; n64_req = 1; n64_addr = 9'h030;
        @(negedge clk);
        total_cnt++;
        if (cpu_rvalid !== 1'b1 || n64_rvalid !== 1'b0 || cpu_rdata !== 32'hC0DE0031 ||
            n64_rdata !== 32'hC0DE0010)
            $display("FAIL b2b_second: crv=%b nrv=%b cd=%h nd=%h", cpu_rvalid, n64_rvalid, cpu_rdata, n64_rdata);
        else pass_cnt++;
        step();
        n64_req = 0;
        @(negedge clk);
        total_cnt++;
        if (n64_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || n64_rdata !== 32'hC0DE0030 ||
            cpu_rdata !== 32'hC0DE0031)
            $display("FAIL b2b_third: nrv=%b crv=%b nd=%h cd=%h", n64_rvalid, cpu_rvalid, n64_rdata, cpu_rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h041;
        n64_req = 1; n64_we = 1; n64_burst = 1;
        for (int i = 0; i < 4; i++) begin
            n64_addr = 9'h180 + 9'(i); n64_wdata = 32'hD0000000 | i;
            step();
        end
        n64_addr = 9'h184; n64_wdata = 32'hD0000004;
        @(negedge clk);
        total_cnt++;
        if (n64_gnt !== 1'b1 || n64_locked !== 1'b1)
            $display("FAIL beat5_pre_reset: gnt=%b lk=%b want 1 1", n64_gnt, n64_locked);
        else pass_cnt++;
        #1 reset_l = 1'b0;
        #1;
        total_cnt++;
        if ({n64_gnt, cpu_gnt, n64_rvalid, cpu_rvalid, ram_we, n64_locked} !== 6'b0 ||
            ram_addr !== 9'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0 ||
            n64_rdata !== 32'h0 || cpu_rdata !== 32'h0)
            $display("FAIL reset_mid_burst: gnt=%b/%b rv=%b/%b we=%b lk=%b addr=%h wd=%h", n64_gnt,
                     cpu_gnt, n64_rvalid, cpu_rvalid, ram_we, n64_locked, ram_addr, ram_wdata);
        else pass_cnt++;
        idle_inputs();
        step();
        reset_l = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        @(negedge clk);
        total_cnt++;
        if (cpu_gnt !== 1'b1 || n64_locked !== 1'b0 || n64_rvalid !== 1'b0)
            $display("FAIL post_reset_gnt: cgnt=%b lk=%b nrv=%b want 1 0 0", cpu_gnt, n64_locked, n64_rvalid);
        else pass_cnt++;
        step();
        cpu_req = 0;
        @(negedge clk);
        total_cnt++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hC0DE0010)
            $display("FAIL post_reset_read: rv=%b data=%h want 1 c0de0010", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
        step();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE0000 | i;
        ram_rdata = '0;
        test_reset();
        test_n64_read();
        test_starve();
        test_burst();
        test_byte_enable();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
